// File: rtl/axi_ram_wr_rd_arb.sv
// Shares one single-port RAM between a write-command stream and a read-command
// stream. Whole bursts are granted and alternate round-robin between the two sides.
// Read data returns through a 2-entry response buffer with backpressure.
module axi_ram_wr_rd_arb #(
    parameter int unsigned DATA_WIDTH       = 32,
    parameter int unsigned ADDR_WIDTH       = 16,
    parameter int unsigned STRB_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned VALID_ADDR_WIDTH = ADDR_WIDTH - $clog2(STRB_WIDTH)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [ADDR_WIDTH-1:0]       i_wr_cmd_addr,
    input  logic [DATA_WIDTH-1:0]       i_wr_cmd_data,
    input  logic [STRB_WIDTH-1:0]       i_wr_cmd_strb,
    input  logic                        i_wr_cmd_en,
    input  logic                        i_wr_cmd_last,
    output logic                        o_wr_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]       i_rd_cmd_addr,
    input  logic                        i_rd_cmd_en,
    input  logic                        i_rd_cmd_last,
    output logic                        o_rd_cmd_ready,
    output logic [DATA_WIDTH-1:0]       o_rd_resp_data,
    output logic                        o_rd_resp_last,
    output logic                        o_rd_resp_valid,
    input  logic                        i_rd_resp_ready,
    output logic [VALID_ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0]       o_ram_wr_data,
    output logic [STRB_WIDTH-1:0]       o_ram_wr_strb,
    output logic                        o_ram_en,
    output logic                        o_ram_we,
    input  logic [DATA_WIDTH-1:0]       i_ram_rd_data
);

    localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);

    typedef enum logic [1:0] {StIdle, StWr, StRd} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_pri;
    logic                  w_pri_nxt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_buf_data [2];
    logic [1:0]            r_buf_last;
    logic                  r_buf_wr_ptr;
    logic                  r_buf_rd_ptr;
    logic [1:0]            r_count;
    logic [1:0]            w_count_nxt;
    logic [1:0]            w_occupancy;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_resp_pop;
    logic                  w_store;
    logic                  w_buf_pop;
    logic                  w_unused;

    // Byte-lane bits of the addresses never reach the word-addressed RAM
    assign w_unused = ^{i_wr_cmd_addr[ADDR_LSB-1:0], i_rd_cmd_addr[ADDR_LSB-1:0]};

    // Handshakes and RAM port, combinational from grant and inputs
    always_comb begin
        w_occupancy     = r_count + {1'b0, r_inflight};
        o_wr_cmd_ready  = (r_state == StWr);
        o_rd_cmd_ready  = (r_state == StRd) && (w_occupancy < 2'd2);
        w_wr_acc        = i_wr_cmd_en && o_wr_cmd_ready;
        w_rd_acc        = i_rd_cmd_en && o_rd_cmd_ready;
        o_ram_en        = w_wr_acc || w_rd_acc;
        o_ram_we        = w_wr_acc;
        o_ram_wr_strb   = w_wr_acc ? i_wr_cmd_strb : '0;
        o_ram_wr_data   = i_wr_cmd_data;
        o_ram_addr      = (r_state == StRd) ? i_rd_cmd_addr[ADDR_WIDTH-1:ADDR_LSB]
                                            : i_wr_cmd_addr[ADDR_WIDTH-1:ADDR_LSB];
    end

    // Response head: buffered entry if any, otherwise RAM data of the beat in flight
    always_comb begin
        o_rd_resp_valid = (r_count != 2'd0) || r_inflight;
        if (r_count != 2'd0) begin
            o_rd_resp_data = r_buf_data[r_buf_rd_ptr];
            o_rd_resp_last = r_buf_last[r_buf_rd_ptr];
        end else begin
            o_rd_resp_data = i_ram_rd_data;
            o_rd_resp_last = r_inflight && r_inflight_last;
        end
        w_resp_pop = o_rd_resp_valid && i_rd_resp_ready;
        // An in-flight beat popped straight off the RAM bus bypasses the buffer
        w_store    = r_inflight && !((r_count == 2'd0) && w_resp_pop);
        w_buf_pop  = w_resp_pop && (r_count != 2'd0);
    end

    // Buffer occupancy next value
    always_comb begin
        w_count_nxt = r_count;
        if (w_store && !w_buf_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_store && w_buf_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    // Arbitration FSM next state and round-robin priority
    always_comb begin
        w_state_nxt = r_state;
        w_pri_nxt   = r_pri;
        unique case (r_state)
            StIdle: begin
                if (i_wr_cmd_en && (!i_rd_cmd_en || !r_pri)) begin
                    w_state_nxt = StWr;
                end else if (i_rd_cmd_en) begin
                    w_state_nxt = StRd;
                end
            end
            StWr: begin
                if (w_wr_acc && i_wr_cmd_last) begin
                    w_state_nxt = StIdle;
                    w_pri_nxt   = 1'b1;
                end
            end
            StRd: begin
                if (w_rd_acc && i_rd_cmd_last) begin
                    w_state_nxt = StIdle;
                    w_pri_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    // FSM state, priority and in-flight read tracking
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= StIdle;
            r_pri           <= 1'b0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pri      <= w_pri_nxt;
            r_inflight <= w_rd_acc;
            if (w_rd_acc) begin
                r_inflight_last <= i_rd_cmd_last;
            end
        end
    end

    // Two-entry response buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= '0;
            r_buf_wr_ptr  <= 1'b0;
            r_buf_rd_ptr  <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (w_store) begin
                r_buf_data[r_buf_wr_ptr] <= i_ram_rd_data;
                r_buf_last[r_buf_wr_ptr] <= r_inflight_last;
                r_buf_wr_ptr             <= ~r_buf_wr_ptr;
            end
            if (w_buf_pop) begin
                r_buf_rd_ptr <= ~r_buf_rd_ptr;
            end
            r_count <= w_count_nxt;
        end
    end

endmodule

// File: doc/axi_ram_wr_rd_arb.md
# axi_ram_wr_rd_arb

Arbiter that shares one single-port RAM between the write-command stream of an AXI RAM write interface and the read-command stream of an AXI RAM read interface. Grants whole bursts (held until the beat flagged `last`), alternates round-robin between sides, drives the RAM port, and returns read data through a 2-entry response buffer with backpressure. Sits between the AXI write/read interface blocks and the RAM array.

## Interface
- `DATA_WIDTH`, 32, data bus width in bits
- `ADDR_WIDTH`, 16, byte address width
- `STRB_WIDTH`, `DATA_WIDTH/8`, byte lanes; power of two
- `VALID_ADDR_WIDTH`, `ADDR_WIDTH-$clog2(STRB_WIDTH)`, RAM word address width (derived)
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `wr_cmd_addr`  in  ADDR_WIDTH  write byte address
- `wr_cmd_data`  in  DATA_WIDTH  write data
- `wr_cmd_strb`  in  STRB_WIDTH  byte enables
- `wr_cmd_en`  in  1  write beat valid
- `wr_cmd_last`  in  1  final beat of write burst
- `wr_cmd_ready`  out  1  write beat accepted when `wr_cmd_en && wr_cmd_ready`
- `rd_cmd_addr`  in  ADDR_WIDTH  read byte address
- `rd_cmd_en`  in  1  read beat valid
- `rd_cmd_last`  in  1  final beat of read burst
- `rd_cmd_ready`  out  1  read beat accepted when `rd_cmd_en && rd_cmd_ready`
- `rd_resp_data`  out  DATA_WIDTH  read data, head of response buffer
- `rd_resp_last`  out  1  `rd_cmd_last` of the beat that produced this data
- `rd_resp_valid`  out  1  response buffer non-empty
- `rd_resp_ready`  in  1  consumer pops when `rd_resp_valid && rd_resp_ready`
- `ram_addr`  out  VALID_ADDR_WIDTH  word address = byte address `[ADDR_WIDTH-1:$clog2(STRB_WIDTH)]`
- `ram_wr_data`  out  DATA_WIDTH  write data (`wr_cmd_data` passthrough)
- `ram_wr_strb`  out  STRB_WIDTH  byte write enables; all zero on reads
- `ram_en`  out  1  RAM access this cycle
- `ram_we`  out  1  access is a write
- `ram_rd_data`  in  DATA_WIDTH  RAM read data, valid exactly 1 cycle after a read access

## Operation
- States: IDLE, WR, RD. Single priority bit `pri` (0 = write preferred, 1 = read preferred).
- IDLE: if only one of `wr_cmd_en`/`rd_cmd_en` high, grant it; if both, grant per `pri`; if neither, stay. No beats accepted in IDLE.
- WR: `wr_cmd_ready = 1`, `rd_cmd_ready = 0`. Accepted beat → `ram_en=1`, `ram_we=1`, `ram_wr_strb=wr_cmd_strb`. Accepted beat with `wr_cmd_last` → IDLE, `pri <= 1`.
- RD: `rd_cmd_ready = (occupancy + inflight < 2)`, `wr_cmd_ready = 0`. Accepted beat → `ram_en=1`, `ram_we=0`, strb zero; sets `inflight` for one cycle, capturing `rd_cmd_last`. Next cycle `ram_rd_data` + captured last pushed into buffer. Accepted beat with `rd_cmd_last` → IDLE, `pri <= 0`.
- RAM outputs combinational from grant and inputs: `ram_en = granted_en && granted_ready`; `ram_addr` muxes granted side's address (write address in IDLE).
- Response buffer: 2-entry FIFO, occupancy 0..2; push and pop same cycle allowed (occupancy unchanged). Overflow impossible by `rd_cmd_ready` rule; must never occur.
- Sides never interleave inside a burst; the other side's `en` is ignored until `last`.
- Reset: state IDLE, `pri=0`, buffer empty, `inflight=0`.

## Timing
- Arbitration costs one IDLE cycle between bursts; first beat of a burst accepted earliest 1 cycle after `en` seen in IDLE.
- Write beat: RAM write occurs the same cycle it is accepted. Throughput 1 beat/cycle.
- Read beat: accepted cycle N, `rd_resp_valid` high at N+1 earliest (buffer was empty). Sustained 1 beat/cycle when `rd_resp_ready` held high.
- With `rd_resp_ready` low: at most 2 beats accepted, then `rd_cmd_ready` low until a pop.
- Reset values: `wr_cmd_ready=0`, `rd_cmd_ready=0`, `rd_resp_valid=0`, `rd_resp_last=0`, `ram_en=0`, `ram_we=0`, `ram_wr_strb=0`; data outputs don't-care.
- Reset mid-burst: all outputs take reset values asynchronously; in-flight read discarded; no RAM access after assertion.

## Test plan
- Single write, addr 0x0010, data 0xDEADBEEF, strb 0xF, last=1 → one cycle `ram_en=1, ram_we=1, ram_addr=4`, back to IDLE.
- 4-beat read from 0x0000, `rd_resp_ready=1` → `ram_addr` 0,1,2,3 on consecutive cycles; 4 responses, `rd_resp_last` only on 4th, each 1 cycle after access.
- Read burst with `rd_resp_ready=0` → exactly 2 beats accepted, `rd_cmd_ready=0`; raise ready → data returned in order, no loss/duplication.
- Both sides request continuously, 2-beat bursts each → grants alternate W,R,W,R starting with W after reset; one IDLE cycle between bursts.
- Write requested mid read burst → write beats not accepted until read `last` accepted.
- Assert `rst_n=0` during beat 2 of 4-beat read → all outputs at reset values immediately; after release, new write burst granted normally, buffer empty.
